// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, lamp encodings and queue limit for the traffic light
package traffic_pkg;

  // Two bits cover all four states, so no encoding is left unreachable.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    EMERG  = 2'd3
  } state_t;

  // Lamp bits are {red, yellow, green}.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [3:0] QUEUE_MAX = 4'd15;

endpackage

// File: rtl/tl_queue_counter.sv
// rtl/tl_queue_counter.sv - 4-bit saturating up/down vehicle queue counter
module tl_queue_counter
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [3:0] o_count
);

  logic [3:0] r_count;

  // Step up or down unless both or neither are requested; clamp at 0 and QUEUE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_inc && !i_dec && (r_count != QUEUE_MAX)) begin
      r_count <= r_count + 4'd1;
    end else if (i_dec && !i_inc && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/smart_traffic_light.sv
// rtl/smart_traffic_light.sv - adaptive single-approach traffic light with emergency preemption
module smart_traffic_light
  import traffic_pkg::*;
#(
  parameter int RED_TIME    = 5,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_detected,
  input  logic       emergency,
  output logic [2:0] lights,
  output logic [3:0] queue_count
);

  // Timer must reach the largest terminal count of any timed state.
  localparam int T_MAX_RG = (RED_TIME > GREEN_MAX) ? RED_TIME : GREEN_MAX;
  localparam int T_MAX    = (T_MAX_RG > YELLOW_TIME) ? T_MAX_RG : YELLOW_TIME;
  localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] RED_LAST    = TW'(RED_TIME - 1);
  localparam logic [TW-1:0] GMIN_LAST   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LAST   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TIME - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_lights;
  logic [3:0]    w_queue;
  logic          w_inc;
  logic          w_dec;

  // Cars queue up while the approach is stopped and drain one per cycle of empty green.
  assign w_inc = (r_state != GREEN) && car_detected;
  assign w_dec = (r_state == GREEN) && !car_detected;

  tl_queue_counter u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (w_queue)
  );

  // Sequencer: emergency preempts everything, otherwise per-state timeouts advance the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RED;
      r_timer  <= '0;
      r_lights <= LIGHT_RED;
    end else if (emergency) begin
      r_state  <= EMERG;
      r_timer  <= '0;
      r_lights <= LIGHT_RED;
    end else begin
      case (r_state)
        RED: begin
          if (r_timer == RED_LAST) begin
            r_state  <= GREEN;
            r_timer  <= '0;
            r_lights <= LIGHT_GREEN;
          end else begin
            r_timer  <= r_timer + TW'(1);
          end
        end
        GREEN: begin
          if ((r_timer == GMAX_LAST) ||
              ((r_timer >= GMIN_LAST) && (w_queue == 4'd0))) begin
            r_state  <= YELLOW;
            r_timer  <= '0;
            r_lights <= LIGHT_YELLOW;
          end else begin
            r_timer  <= r_timer + TW'(1);
          end
        end
        YELLOW: begin
          if (r_timer == YELLOW_LAST) begin
            r_state  <= RED;
            r_timer  <= '0;
            r_lights <= LIGHT_RED;
          end else begin
            r_timer  <= r_timer + TW'(1);
          end
        end
        EMERG: begin
          // Release always restarts a full red phase.
          r_state  <= RED;
          r_timer  <= '0;
          r_lights <= LIGHT_RED;
        end
        default: begin
          r_state  <= RED;
          r_timer  <= '0;
          r_lights <= LIGHT_RED;
        end
      endcase
    end
  end

  assign lights      = r_lights;
  assign queue_count = w_queue;

endmodule

// File: tb/tb_smart_traffic_light.sv
// tb/tb_smart_traffic_light.sv - directed self-checking bench for smart_traffic_light
module tb_smart_traffic_light;

  logic       clk;
  logic       rst;
  logic       car_detected;
  logic       emergency;
  logic [2:0] lights;
  logic [3:0] queue_count;

  int checks;
  int errors;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  smart_traffic_light dut (
    .clk          (clk),
    .rst          (rst),
    .car_detected (car_detected),
    .emergency    (emergency),
    .lights       (lights),
    .queue_count  (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    car_detected = 1'b0;
    emergency    = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_l;
    @(negedge clk);
    rst          = 1'b1;
    car_detected = 1'b1;
    emergency    = 1'b0;
    #1;
    checks++;
    if (lights !== L_R || queue_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_assert: lights=%b queue=%0d, required lights=100 queue=0", lights, queue_count);
    end
    step();
    checks++;
    if (lights !== L_R || queue_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_held: lights=%b queue=%0d, required lights=100 queue=0", lights, queue_count);
    end
    rst          = 1'b0;
    car_detected = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k < 5)       exp_l = L_R;
      else if (k < 9)  exp_l = L_G;
      else if (k < 11) exp_l = L_Y;
      else if (k < 16) exp_l = L_R;
      else if (k < 20) exp_l = L_G;
      else if (k < 22) exp_l = L_Y;
      else             exp_l = L_R;
      checks++;
      if (lights !== exp_l || queue_count !== 4'd0) begin
        errors++;
        $display("FAIL normal_cycle k=%0d: lights=%b queue=%0d, required lights=%b queue=0", k, lights, queue_count, exp_l);
      end
      step();
    end
  endtask

  task automatic test_adaptive_green();
    logic [2:0] exp_l;
    logic [3:0] exp_q;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      car_detected = (k < 10);
      if (k < 5)       exp_l = L_R;
      else if (k < 15) exp_l = L_G;
      else if (k < 17) exp_l = L_Y;
      else             exp_l = L_R;
      if (k <= 5)       exp_q = 4'(k);
      else if (k <= 10) exp_q = 4'd5;
      else if (k <= 15) exp_q = 4'(15 - k);
      else              exp_q = 4'd0;
      checks++;
      if (lights !== exp_l || queue_count !== exp_q) begin
        errors++;
        $display("FAIL adaptive_green k=%0d: lights=%b queue=%0d, required lights=%b queue=%0d", k, lights, queue_count, exp_l, exp_q);
      end
      step();
    end
    car_detected = 1'b0;
  endtask

  task automatic test_saturation();
    logic [2:0] exp_l;
    logic [3:0] exp_q;
    do_reset();
    for (int k = 0; k < 56; k++) begin
      emergency    = (k < 20);
      car_detected = (k < 20);
      if (k <= 25)      exp_l = L_R;
      else if (k <= 35) exp_l = L_G;
      else if (k <= 37) exp_l = L_Y;
      else if (k <= 42) exp_l = L_R;
      else if (k <= 48) exp_l = L_G;
      else if (k <= 50) exp_l = L_Y;
      else              exp_l = L_R;
      if (k < 15)       exp_q = 4'(k);
      else if (k <= 26) exp_q = 4'd15;
      else if (k <= 36) exp_q = 4'(15 - (k - 26));
      else if (k <= 43) exp_q = 4'd5;
      else if (k <= 48) exp_q = 4'(5 - (k - 43));
      else              exp_q = 4'd0;
      checks++;
      if (lights !== exp_l || queue_count !== exp_q) begin
        errors++;
        $display("FAIL saturation k=%0d: lights=%b queue=%0d, required lights=%b queue=%0d", k, lights, queue_count, exp_l, exp_q);
      end
      step();
    end
    emergency    = 1'b0;
    car_detected = 1'b0;
  endtask

  task automatic test_emergency_green();
    logic [2:0] exp_l;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      emergency = (k >= 6 && k <= 8);
      if (k < 5)       exp_l = L_R;
      else if (k < 7)  exp_l = L_G;
      else if (k < 15) exp_l = L_R;
      else if (k < 19) exp_l = L_G;
      else             exp_l = L_Y;
      checks++;
      if (lights !== exp_l || queue_count !== 4'd0) begin
        errors++;
        $display("FAIL emergency_green k=%0d: lights=%b queue=%0d, required lights=%b queue=0", k, lights, queue_count, exp_l);
      end
      step();
    end
    emergency = 1'b0;
  endtask

  task automatic test_emergency_priority();
    logic [2:0] exp_l;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      emergency = (k == 4);
      if (k < 11)      exp_l = L_R;
      else if (k < 15) exp_l = L_G;
      else             exp_l = L_Y;
      checks++;
      if (lights !== exp_l) begin
        errors++;
        $display("FAIL emergency_priority k=%0d: lights=%b, required %b", k, lights, exp_l);
      end
      step();
    end
    emergency = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 23; k++) begin
      emergency    = (k <= 6);
      car_detected = (k <= 6) || (k >= 13 && k <= 22);
      step();
    end
    emergency    = 1'b0;
    car_detected = 1'b0;
    checks++;
    if (lights !== L_Y || queue_count !== 4'd7) begin
      errors++;
      $display("FAIL async_setup: lights=%b queue=%0d, required lights=010 queue=7", lights, queue_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (lights !== L_R || queue_count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: lights=%b queue=%0d, required lights=100 queue=0 before any edge", lights, queue_count);
    end
    step();
    rst = 1'b0;
    checks++;
    if (lights !== L_R || queue_count !== 4'd0) begin
      errors++;
      $display("FAIL async_release: lights=%b queue=%0d, required lights=100 queue=0", lights, queue_count);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    car_detected = 1'b0;
    emergency    = 1'b0;
    test_reset();
    test_adaptive_green();
    test_saturation();
    test_emergency_green();
    test_emergency_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smart_traffic_light.md
Name: smart_traffic_light

Overview:
- Single-approach traffic-light controller: a Moore FSM cycles RED -> GREEN -> YELLOW -> RED using per-state cycle timers.
- Green time is adaptive to a 4-bit saturating vehicle-queue estimate fed by a car-detect sensor.
- An emergency input preempts normal sequencing and holds RED.
- Sits between the intersection sensor inputs and the lamp drivers.

Parameters:
- RED_TIME, 5, cycles spent in RED per normal pass (≥1).
- GREEN_MIN, 4, minimum GREEN cycles (≥1).
- GREEN_MAX, 10, maximum GREEN cycles (≥ GREEN_MIN).
- YELLOW_TIME, 2, cycles spent in YELLOW (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- car_detected  in  1  vehicle present/arriving this cycle (level, sampled each clock).
- emergency  in  1  emergency-vehicle preemption request (level).
- lights  out  3  {red, yellow, green}: RED=3'b100, YELLOW=3'b010, GREEN=3'b001; exactly one bit set at all times.
- queue_count  out  4  saturating queued-vehicle estimate, 0..15.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1: state=RED, timer=0, lights=3'b100, queue_count=0. Reset asserted mid-operation aborts any state immediately (asynchronously) to these values.
- Outputs are registered/Moore: lights is a pure function of the state register. The EMERG state drives 3'b100.
- The state timer counts cycles spent in the current state. It clears to 0 on every state change and on emergency release.
- RED: exits to GREEN at the clock edge where timer == RED_TIME-1, so RED is visible for exactly RED_TIME cycles.
- GREEN exits to YELLOW at the edge where either condition holds:
  - timer == GREEN_MAX-1; or
  - timer ≥ GREEN_MIN-1 and queue_count == 0.
- YELLOW: exits to RED at the edge where timer == YELLOW_TIME-1.
- Emergency:
  - emergency=1 sampled in any state -> next state EMERG (lights=3'b100 the following cycle). Green is cut immediately; no yellow.
  - Remain in EMERG while emergency=1.
  - On the first edge with emergency=0, go to RED with timer=0; a full RED_TIME follows.
  - Emergency has priority over every timer transition in the same cycle.
- queue_count update, per clock, saturating:
  - Not GREEN (RED/YELLOW/EMERG) and car_detected=1: +1, capped at 15.
  - GREEN and car_detected=0: -1, floored at 0.
  - GREEN and car_detected=1: hold (one arrives, one departs).
  - Not GREEN and car_detected=0: hold.
- queue_count never wraps: 15+1 stays 15, 0-1 stays 0.
- Timer width must hold GREEN_MAX-1. No illegal state may be reachable; unused encodings recover to RED.

Decomposition:
- Shared package (traffic_pkg):
  - state enum: RED, GREEN, YELLOW, EMERG.
  - light encoding constants: LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001.
  - QUEUE_MAX=15.
- One sub-module, tl_queue_counter: 4-bit saturating up/down counter.
  - Inputs: inc, dec, hold-on-both.
  - Same clk/rst.
- The FSM and timer stay in the top module.

Test Plan:
- Reset (rst=1 for 1 cycle, then 0), no cars -> lights=100 and queue=0 during reset. After release, RED for 5 cycles, GREEN for 4 cycles (queue=0 at GREEN_MIN), YELLOW for 2 cycles, then RED; repeats.
- car_detected=1 for 10 cycles from reset release, then 0 -> queue climbs 1..5 during RED, holds 5 during the first 5 GREEN cycles, then decrements to 0. GREEN lasts 10 cycles (GREEN_MAX), then YELLOW for 2 cycles.
- car_detected=1 held for 20 cycles in RED-heavy operation -> queue saturates at 15 and never wraps to 0. In GREEN with car_detected=0, it decrements to 0 and stays at 0.
- emergency=1 pulsed for 3 cycles mid-GREEN -> lights=100 on the next cycle, with no yellow phase. lights stays 100 while asserted, then a full 5-cycle RED, then GREEN.
- emergency=1 asserted on the same edge as a RED->GREEN timeout -> EMERG wins and lights stays 100.
- rst asserted asynchronously mid-YELLOW with queue=7 -> lights=100 and queue=0 immediately, without waiting for a clock edge.
